// File: rtl/multi_clock_gen.sv
// ---------------------------------------------------------------------------
// multi_clock_gen
//   Multi-channel, runtime-programmable clock/tick generator. Each channel
//   divides clk_in by a programmable terminal count and produces either a 50%
//   square wave or a one-cycle pulse. New settings wait in a per-channel shadow
//   register and take effect only at a period boundary, so an output never
//   glitches mid-period.
//
// Ports
//   clk_in     in   1          system clock, all logic on the rising edge
//   reset      in   1          synchronous, active-high, overrides everything
//   enable     in   CHANNELS   per-channel run enable
//   cfg_valid  in   1          configuration request
//   cfg_ready  out  1          configuration accept (combinational)
//   cfg_chan   in   CH_W       target channel of the request
//   cfg_tc     in   CNT_WIDTH  new terminal count
//   cfg_mode   in   1          new mode: 0 square, 1 tick
//   clk_out    out  CHANNELS   per-channel generated output (registered)
//   tick       out  CHANNELS   per-channel one-cycle wrap pulse (registered)
// ---------------------------------------------------------------------------
module multi_clock_gen #(
   parameter int          CHANNELS     = 4,
   parameter int          CNT_WIDTH    = 24,
   parameter int unsigned DEFAULT_TC   = 833332,
   parameter logic        DEFAULT_MODE = 1'b0,
   localparam int         CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  enable,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_W-1:0]      cfg_chan,
   input  logic [CNT_WIDTH-1:0] cfg_tc,
   input  logic                 cfg_mode,
   output logic [CHANNELS-1:0]  clk_out,
   output logic [CHANNELS-1:0]  tick
);

   typedef enum logic [1:0] {
      CH_OFF      = 2'd0,
      CH_RUN      = 2'd1,
      CH_RUN_PEND = 2'd2
   } chan_state_t;

   logic [CHANNELS-1:0] pending;
   logic                cfg_fire;

   // A channel can hold only one waiting configuration, so the request is
   // refused while the addressed channel already has one. Requests aimed
   // past the last channel are always accepted and simply dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (pending[i] && (cfg_chan == CH_W'(i))) begin
            cfg_ready = 1'b0;
         end
      end
   end

   assign cfg_fire = cfg_valid && cfg_ready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic [CNT_WIDTH-1:0] tc_q, tc_d;
      logic [CNT_WIDTH-1:0] sh_tc_q, sh_tc_d;
      logic                 mode_q, mode_d;
      logic                 sh_mode_q, sh_mode_d;
      logic                 pend_q, pend_d;
      logic                 clk_q, clk_d;
      logic                 tick_q, tick_d;
      logic                 load;
      logic                 wrap;
      chan_state_t          state;

      // The channel state is fully determined by its enable and whether a
      // shadow configuration is waiting; OFF wins over everything else.
      always_comb begin
         if (!enable[g]) begin
            state = CH_OFF;
         end else if (pend_q) begin
            state = CH_RUN_PEND;
         end else begin
            state = CH_RUN;
         end
      end

      assign load    = cfg_fire && (cfg_chan == CH_W'(g));
      assign wrap    = (cnt_q == tc_q);
      assign pending[g] = pend_q;

      // Next-state logic. The shadow config is applied from the value held
      // before this edge, so a request landing on a wrap edge waits for the
      // following wrap. A mode change at apply parks the output low so the
      // new mode starts from a clean level; the wrap pulse still fires.
      always_comb begin
         cnt_d     = cnt_q;
         tc_d      = tc_q;
         mode_d    = mode_q;
         sh_tc_d   = sh_tc_q;
         sh_mode_d = sh_mode_q;
         pend_d    = pend_q;
         clk_d     = clk_q;
         tick_d    = 1'b0;
         case (state)
            CH_OFF: begin
               cnt_d = '0;
               clk_d = 1'b0;
               if (pend_q) begin
                  tc_d   = sh_tc_q;
                  mode_d = sh_mode_q;
                  pend_d = 1'b0;
               end
            end
            CH_RUN, CH_RUN_PEND: begin
               if (wrap) begin
                  cnt_d  = '0;
                  tick_d = 1'b1;
                  if (state == CH_RUN_PEND) begin
                     tc_d   = sh_tc_q;
                     mode_d = sh_mode_q;
                     pend_d = 1'b0;
                  end
                  if (mode_d != mode_q) begin
                     clk_d = 1'b0;
                  end else if (mode_q) begin
                     clk_d = 1'b1;
                  end else begin
                     clk_d = !clk_q;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (mode_q) begin
                     clk_d = 1'b0;
                  end
               end
            end
            default: begin
               cnt_d = '0;
               clk_d = 1'b0;
            end
         endcase
         if (load) begin
            sh_tc_d   = cfg_tc;
            sh_mode_d = cfg_mode;
            pend_d    = 1'b1;
         end
      end

      // State register. Reset restores the default divider and throws away
      // any configuration that was still waiting in the shadow register.
      always_ff @(posedge clk_in) begin
         if (reset) begin
            cnt_q     <= '0;
            tc_q      <= CNT_WIDTH'(DEFAULT_TC);
            mode_q    <= DEFAULT_MODE;
            sh_tc_q   <= CNT_WIDTH'(DEFAULT_TC);
            sh_mode_q <= DEFAULT_MODE;
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            mode_q    <= mode_d;
            sh_tc_q   <= sh_tc_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
         end
      end

      // Outputs come straight from flops so downstream logic sees clean edges.
      assign clk_out[g] = clk_q;
      assign tick[g]    = tick_q;
   end

endmodule

// File: tb/tb_multi_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_gen
//   Directed bench for multi_clock_gen. A table of per-cycle vectors covers
//   reset, the default divider and programming an idle channel; hand-written
//   sequences cover reprogramming at a wrap, handshake back-pressure, tc=0,
//   mode swaps and reset with a waiting configuration. The default terminal
//   count is scaled down to 5 so each period is only a handful of cycles.
// ---------------------------------------------------------------------------
module tb_multi_clock_gen;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [3:0]  enable;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_chan;
   logic [23:0] cfg_tc;
   logic        cfg_mode;
   logic [3:0]  clk_out;
   logic [3:0]  tick;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  en;
      logic        valid;
      logic [1:0]  chan;
      logic [23:0] tc;
      logic        mode;
      logic        expReady;
      logic [3:0]  expClk;
      logic [3:0]  expTick;
   } vec_t;

   vec_t vecs[$];

   multi_clock_gen #(
      .CHANNELS    (4),
      .CNT_WIDTH   (24),
      .DEFAULT_TC  (5),
      .DEFAULT_MODE(1'b0)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .enable   (enable),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_chan (cfg_chan),
      .cfg_tc   (cfg_tc),
      .cfg_mode (cfg_mode),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   // 10 ns clock period.
   always #5 clk_in = !clk_in;

   // Inputs change on the falling edge, well clear of the sampling edge.
   task automatic applyStimulus(input logic rst, input logic [3:0] en,
                                input logic valid, input logic [1:0] chan,
                                input logic [23:0] tc, input logic mode);
      @(negedge clk_in);
      reset     = rst;
      enable    = en;
      cfg_valid = valid;
      cfg_chan  = chan;
      cfg_tc    = tc;
      cfg_mode  = mode;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkReady(input string name, input logic expReady);
      #1;
      checkCount++;
      if (cfg_ready !== expReady) begin
         errorCount++;
         $display("[TB] FAIL %s cfg_ready got %b expected %b", name, cfg_ready, expReady);
      end
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expClk,
                              input logic [3:0] expTick);
      checkCount++;
      if (clk_out !== expClk) begin
         errorCount++;
         $display("[TB] FAIL %s clk_out got %b expected %b", name, clk_out, expClk);
      end
      checkCount++;
      if (tick !== expTick) begin
         errorCount++;
         $display("[TB] FAIL %s tick got %b expected %b", name, tick, expTick);
      end
   endtask

   task automatic addVec(input logic rst, input logic [3:0] en, input logic valid,
                         input logic [1:0] chan, input logic [23:0] tc,
                         input logic mode, input logic expReady,
                         input logic [3:0] expClk, input logic [3:0] expTick);
      vec_t v;
      v.rst      = rst;
      v.en       = en;
      v.valid    = valid;
      v.chan     = chan;
      v.tc       = tc;
      v.mode     = mode;
      v.expReady = expReady;
      v.expClk   = expClk;
      v.expTick  = expTick;
      vecs.push_back(v);
   endtask

   initial begin
      logic c;
      logic t;
      logic v;
      logic r;
      logic [1:0]  ch;
      logic [23:0] tcv;
      logic        md;

      reset     = 1'b1;
      enable    = 4'b0000;
      cfg_valid = 1'b0;
      cfg_chan  = 2'd0;
      cfg_tc    = 24'd0;
      cfg_mode  = 1'b0;

      // Table: reset, then ch0 on the default tc=5 (toggle every 6 cycles).
      addVec(1'b1, 4'b0000, 1'b0, 2'd0, 24'd0, 1'b0, 1'b1, 4'b0000, 4'b0000);
      addVec(1'b1, 4'b0000, 1'b0, 2'd0, 24'd0, 1'b0, 1'b1, 4'b0000, 4'b0000);
      for (int k = 1; k <= 13; k++) begin
         c = (k >= 6) && (k < 12);
         t = (k == 6) || (k == 12);
         addVec(1'b0, 4'b0001, 1'b0, 2'd0, 24'd0, 1'b0, 1'b1, {3'b000, c}, {3'b000, t});
      end
      // Table: program ch1 tc=3 square while idle, then enable it (period 8).
      addVec(1'b1, 4'b0000, 1'b0, 2'd0, 24'd0, 1'b0, 1'b1, 4'b0000, 4'b0000);
      addVec(1'b0, 4'b0000, 1'b1, 2'd1, 24'd3, 1'b0, 1'b1, 4'b0000, 4'b0000);
      addVec(1'b0, 4'b0000, 1'b0, 2'd1, 24'd0, 1'b0, 1'b0, 4'b0000, 4'b0000);
      addVec(1'b0, 4'b0000, 1'b0, 2'd1, 24'd0, 1'b0, 1'b1, 4'b0000, 4'b0000);
      for (int k = 1; k <= 12; k++) begin
         c = ((k >= 4) && (k < 8)) || (k >= 12);
         t = (k % 4) == 0;
         addVec(1'b0, 4'b0010, 1'b0, 2'd1, 24'd0, 1'b0, 1'b1, {2'b00, c, 1'b0}, {2'b00, t, 1'b0});
      end

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].chan,
                       vecs[i].tc, vecs[i].mode);
         checkReady($sformatf("vec%0d", i), vecs[i].expReady);
         step();
         checkOutput($sformatf("vec%0d", i), vecs[i].expClk, vecs[i].expTick);
      end

      // ch2 tick mode tc=9, reprogrammed to tc=4 mid-period; a second request
      // to ch2 is refused while the first waits, ch3 is accepted meanwhile.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd2, 24'd0, 1'b0);
      step();
      checkOutput("t3_reset", 4'b0000, 4'b0000);
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd2, 24'd9, 1'b1);
      checkReady("t3_cfg_idle", 1'b1);
      step();
      applyStimulus(1'b0, 4'b0000, 1'b0, 2'd2, 24'd0, 1'b0);
      checkReady("t3_pend_idle", 1'b0);
      step();
      for (int k = 1; k <= 30; k++) begin
         v   = 1'b0;
         ch  = 2'd2;
         tcv = 24'd0;
         md  = 1'b0;
         r   = !((k >= 14) && (k <= 20));
         if (k == 13) begin
            v = 1'b1; tcv = 24'd4; md = 1'b1;
         end
         if (k == 15) begin
            v = 1'b1; tcv = 24'd7; md = 1'b1;
         end
         if (k == 16) begin
            v = 1'b1; ch = 2'd3; tcv = 24'd1; md = 1'b0; r = 1'b1;
         end
         applyStimulus(1'b0, 4'b0100, v, ch, tcv, md);
         checkReady($sformatf("t3_ready_k%0d", k), r);
         step();
         t = (k == 10) || (k == 20) || (k == 25) || (k == 30);
         checkOutput($sformatf("t3_k%0d", k), {1'b0, t, 2'b00}, {1'b0, t, 2'b00});
      end
      // ch3 must now run the accepted tc=1 square setting.
      for (int j = 1; j <= 4; j++) begin
         applyStimulus(1'b0, 4'b1000, 1'b0, 2'd3, 24'd0, 1'b0);
         step();
         c = (j == 2) || (j == 3);
         t = (j % 2) == 0;
         checkOutput($sformatf("t4_ch3_j%0d", j), {c, 3'b000}, {t, 3'b000});
      end

      // ch0 tc=0 square gives clk_in/2, then swap to tick mode.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 24'd0, 1'b0);
      step();
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd0, 24'd0, 1'b0);
      step();
      applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 24'd0, 1'b0);
      step();
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 4'b0001, (k == 8), 2'd0, 24'd0, 1'b1);
         step();
         if (k <= 8) begin
            c = (k % 2) == 1;
         end else begin
            c = (k >= 10);
         end
         checkOutput($sformatf("t5_k%0d", k), {3'b000, c}, 4'b0001);
      end

      // Reset mid-period with a waiting config on ch1: config must be lost.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd1, 24'd0, 1'b0);
      step();
      for (int k = 1; k <= 8; k++) begin
         applyStimulus((k == 8), 4'b0010, (k == 7), 2'd1, 24'd1, 1'b1);
         checkReady($sformatf("t6_ready_k%0d", k), (k != 8));
         step();
         c = (k == 6) || (k == 7);
         t = (k == 6);
         checkOutput($sformatf("t6_k%0d", k), {2'b00, c, 1'b0}, {2'b00, t, 1'b0});
      end
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b0, 4'b0010, 1'b0, 2'd1, 24'd0, 1'b0);
         if (k == 1) begin
            checkReady("t6_after_reset", 1'b1);
         end
         step();
         c = (k >= 6);
         t = (k == 6);
         checkOutput($sformatf("t6_resume_k%0d", k), {2'b00, c, 1'b0}, {2'b00, t, 1'b0});
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
